// File: rtl/frame_scheduler.sv
// frame_scheduler: double-buffer frame sequencer for the LED strip array.
// The SPI writer fills the back bank while the strip drivers read the front
// bank. Banks are swapped only when a whole frame is pending, no SPI write is
// in progress and all drivers are idle. The scheduler then holds the LED latch
// gap and pulses a common start to every driver. With no new frame, the front
// bank is re-sent periodically.
module frame_scheduler #(
   parameter int NUM_DRIVERS    = 8,
   parameter int CLOCK_FREQ_MHZ = 50,
   parameter int LATCH_US       = 300,
   parameter int REFRESH_MS     = 50
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   wr_active,
   input  logic                   wr_frame_end,
   input  logic [NUM_DRIVERS-1:0] drv_busy,
   output logic [NUM_DRIVERS-1:0] drv_start,
   output logic                   rd_bank,
   output logic                   wr_bank,
   output logic [15:0]            frame_count,
   output logic [7:0]             dropped_count
);

   localparam int LATCH_CYCLES   = LATCH_US * CLOCK_FREQ_MHZ;
   localparam int LATCH_W        = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
   localparam int REFRESH_CYCLES = REFRESH_MS * 1000 * CLOCK_FREQ_MHZ;
   localparam int REF_W          = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   localparam logic [LATCH_W-1:0] LATCH_LOAD = LATCH_W'(LATCH_CYCLES - 1);
   localparam logic [REF_W-1:0]   REF_LAST   = (REFRESH_CYCLES > 0) ? REF_W'(REFRESH_CYCLES - 1) : REF_W'(0);
   localparam logic               REF_EN     = (REFRESH_CYCLES > 0) ? 1'b1 : 1'b0;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_DRAIN = 3'd1;
   localparam logic [2:0] ST_LATCH = 3'd2;
   localparam logic [2:0] ST_SWAP  = 3'd3;
   localparam logic [2:0] ST_START = 3'd4;

   logic [2:0]             state_r;
   logic [2:0]             state_nxt_s;
   logic                   pending_r;
   logic                   do_swap_r;
   logic [LATCH_W-1:0]     latch_cnt_r;
   logic [REF_W-1:0]       refresh_cnt_r;
   logic                   rd_bank_r;
   logic                   wr_bank_r;
   logic [NUM_DRIVERS-1:0] drv_start_r;
   logic [15:0]            frame_count_r;
   logic [7:0]             dropped_count_r;
   logic                   refresh_due_s;
   logic                   drain_ok_s;
   logic                   latch_done_s;

   assign drv_start     = drv_start_r;
   assign rd_bank       = rd_bank_r;
   assign wr_bank       = wr_bank_r;
   assign frame_count   = frame_count_r;
   assign dropped_count = dropped_count_r;

   // Qualifiers: refresh timeout, drivers/writer quiet, latch gap elapsed.
   always_comb begin
      refresh_due_s = REF_EN && (refresh_cnt_r == REF_LAST);
      drain_ok_s    = (drv_busy == {NUM_DRIVERS{1'b0}}) && (!do_swap_r || !wr_active);
      latch_done_s  = (latch_cnt_r == {LATCH_W{1'b0}});
   end

   // Next-state logic of the sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (pending_r || refresh_due_s) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (drain_ok_s) begin
               state_nxt_s = ST_LATCH;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_LATCH: begin
            if (latch_done_s) begin
               state_nxt_s = ST_SWAP;
            end else begin
               state_nxt_s = ST_LATCH;
            end
         end
         ST_SWAP:  state_nxt_s = ST_START;
         ST_START: state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // Pending-frame flag and saturating count of frames overwritten undisplayed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pending_r       <= 1'b0;
         dropped_count_r <= 8'h00;
      end else begin
         if (wr_frame_end && pending_r && (dropped_count_r != 8'hFF)) begin
            dropped_count_r <= dropped_count_r + 8'd1;
         end
         // A frame ending in the swap cycle is already in the bank going to
         // the front, so the clear takes priority over the set.
         if ((state_r == ST_SWAP) && do_swap_r) begin
            pending_r <= 1'b0;
         end else if (wr_frame_end) begin
            pending_r <= 1'b1;
         end
      end
   end

   // Sequencer state, latch/refresh timers, bank select and start pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r       <= ST_IDLE;
         do_swap_r     <= 1'b0;
         latch_cnt_r   <= {LATCH_W{1'b0}};
         refresh_cnt_r <= {REF_W{1'b0}};
         rd_bank_r     <= 1'b0;
         wr_bank_r     <= 1'b1;
         drv_start_r   <= {NUM_DRIVERS{1'b0}};
         frame_count_r <= 16'h0000;
      end else begin
         state_r <= state_nxt_s;

         if ((state_r == ST_IDLE) && (pending_r || refresh_due_s)) begin
            do_swap_r <= pending_r;
         end

         if ((state_r == ST_DRAIN) && drain_ok_s) begin
            latch_cnt_r <= LATCH_LOAD;
         end else if ((state_r == ST_LATCH) && !latch_done_s) begin
            latch_cnt_r <= latch_cnt_r - LATCH_W'(1);
         end

         if (state_r == ST_START) begin
            refresh_cnt_r <= {REF_W{1'b0}};
         end else if ((state_r == ST_IDLE) && (refresh_cnt_r != REF_LAST)) begin
            refresh_cnt_r <= refresh_cnt_r + REF_W'(1);
         end

         // Bank bits flip on entry to SWAP so the new front bank is already
         // presented during the SWAP cycle, one cycle before the start pulse.
         if ((state_r == ST_LATCH) && latch_done_s && do_swap_r) begin
            rd_bank_r     <= ~rd_bank_r;
            wr_bank_r     <= rd_bank_r;
            frame_count_r <= frame_count_r + 16'd1;
         end

         if (state_r == ST_SWAP) begin
            drv_start_r <= {NUM_DRIVERS{1'b1}};
         end else begin
            drv_start_r <= {NUM_DRIVERS{1'b0}};
         end
      end
   end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
Double-buffer frame sequencer for the LED strip array. The SPI memory controller writes into the back bank of BRAM while the strip drivers read from the front bank. The scheduler swaps the banks only when a complete frame is pending, no SPI write is in progress, and every strip driver is idle. It then enforces the LED latch gap and pulses a synchronous start to all drivers. With no new frame, it periodically re-sends the front bank.

Parameters:
NUM_DRIVERS, 8, number of strip drivers, width of drv_busy/drv_start
CLOCK_FREQ_MHZ, 50, clk frequency, used to derive cycle counts
LATCH_US, 300, minimum low/latch gap before each start; LATCH_CYCLES = LATCH_US*CLOCK_FREQ_MHZ
REFRESH_MS, 50, idle re-send period; 0 disables refresh; REFRESH_CYCLES = REFRESH_MS*1000*CLOCK_FREQ_MHZ

Ports:
clk  input  1  system clock (PLL 50 MHz domain)
resetn  input  1  asynchronous active-low reset
wr_active  input  1  SPI chip-select active (spi_selected); a write is in progress
wr_frame_end  input  1  one-cycle pulse, complete frame written to back bank
drv_busy  input  NUM_DRIVERS  per-driver busy; must rise within 1 cycle of drv_start
drv_start  output  NUM_DRIVERS  one-cycle start pulse, all bits asserted together
rd_bank  output  1  BRAM address MSB for driver/arbiter reads (front bank)
wr_bank  output  1  BRAM address MSB for SPI writes (back bank); always ~rd_bank
frame_count  output  16  frames swapped in, wraps at 16'hFFFF -> 0
dropped_count  output  8  frames overwritten before display, saturates at 8'hFF

Behaviour:
- Reset (async, resetn low): state IDLE, rd_bank=0, wr_bank=1, drv_start=0, frame_count=0, dropped_count=0, pending=0, do_swap=0, latch and refresh counters cleared. drv_start drops immediately on resetn low, even mid-pulse.
- pending flag: set on wr_frame_end. If wr_frame_end arrives while pending=1, dropped_count increments (saturating). pending stays 1 because the newer data is in the same bank.
- States and transitions:
  - IDLE: if pending, then do_swap=1 and go to DRAIN. Else, if REFRESH_MS!=0 and refresh counter has reached REFRESH_CYCLES-1, then do_swap=0 and go to DRAIN. The refresh counter increments every cycle in IDLE.
  - DRAIN: wait until drv_busy==0, and also wr_active==0 if do_swap. Then load the latch counter with LATCH_CYCLES-1 and go to LATCH.
  - LATCH: decrement each cycle; at 0, go to SWAP. Total LATCH residency is exactly LATCH_CYCLES.
  - SWAP (1 cycle): if do_swap, toggle rd_bank/wr_bank, clear pending, and increment frame_count. Go to START.
  - START (1 cycle): drv_start = all ones (registered output, high exactly this cycle). Clear refresh counter. Go to IDLE.
- Latency from wr_frame_end (drivers idle, wr_active low) to drv_start high: 1 (IDLE) + 1 (DRAIN) + LATCH_CYCLES + 1 (SWAP) + 1 = LATCH_CYCLES+4 cycles.
- DRAIN is entered no earlier than 2 cycles after drv_start, so drivers have one cycle to raise busy.
- wr_frame_end in the SWAP cycle with do_swap=1: the clear wins and pending ends at 0, since that data is already in the bank going to front. Count it as dropped only if pending was already 1 (normal rule).
- wr_frame_end during DRAIN/LATCH: pending updates normally. If do_swap=0, the refresh still completes without swap; the frame is serviced on the next IDLE.
- Bank bits change only in SWAP, never while any drv_busy is high or while wr_active is high.
- Counters sized with $clog2 of their cycle count (min 1 bit). No combinational path from inputs to outputs.

Test Plan:
- Reset: LATCH_US=1, CLOCK_FREQ_MHZ=50. Hold resetn low, then release. Required: rd_bank=0, wr_bank=1, drv_start=0, counts=0, no start before any frame or refresh.
- Single frame: drivers idle, pulse wr_frame_end at cycle T. Required: drv_start=8'hFF exactly at T+54 for one cycle; rd_bank=1, wr_bank=0 from T+53; frame_count=1.
- Busy gating: drv_busy=8'h04 held 200 cycles, then wr_frame_end. Required: no swap/start until 54 cycles after drv_busy returns to 0.
- Write-in-progress: wr_active=1 with pending set and drivers idle. Required: stays in DRAIN, banks unchanged; swap proceeds after wr_active falls.
- Drops/saturation: 3 wr_frame_end pulses while drivers busy. Required: dropped_count=2, then a single swap, frame_count+1. Then 300 extra overlaps, required: dropped_count=8'hFF.
- Refresh and mid-op reset: REFRESH_MS=1, no frames. Required: drv_start every 50000+LATCH_CYCLES+3 cycles, banks unchanged, frame_count=0. Assert resetn low during LATCH: outputs return to reset values immediately and there is no start pulse.
